// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory arbiter between the CPU MEM stage and a DMA loader
// Wait-count aging lets a starved DMA win; locked DMA bursts own the memory for up to MAX_BURST beats.
module dmem_arbiter #(
  parameter int DMEM_ADDR_WIDTH = 10,
  parameter int REG_WIDTH       = 32,
  parameter int MAX_WAIT        = 4,
  parameter int MAX_BURST       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [REG_WIDTH-1:0]       cpu_wdata,
  output logic                       cpu_stall,
  output logic [REG_WIDTH-1:0]       cpu_rdata,
  output logic                       cpu_rvalid,
  input  logic                       dma_req,
  input  logic                       dma_we,
  input  logic                       dma_lock,
  input  logic [DMEM_ADDR_WIDTH-1:0] dma_addr,
  input  logic [REG_WIDTH-1:0]       dma_wdata,
  output logic                       dma_gnt,
  output logic [REG_WIDTH-1:0]       dma_rdata,
  output logic                       dma_rvalid,
  output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]       mem_din,
  output logic                       mem_read,
  output logic                       mem_write,
  input  logic [REG_WIDTH-1:0]       mem_dout
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int BEAT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [BEAT_W-1:0] BURST_MAX = BEAT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CPU_OWN   = 2'd1,
    DMA_OWN   = 2'd2,
    DMA_BURST = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  state_t              open_arb;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   wait_next;
  logic [WAIT_W-1:0]   wait_eff;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [BEAT_W-1:0]   beat_next;
  logic                burst_hold;
  logic                dma_wins;
  logic                cpu_grant;
  logic                dma_grant;
  logic                tag_cpu;
  logic                tag_dma;
  logic [REG_WIDTH-1:0] cpu_rdata_q;
  logic [REG_WIDTH-1:0] dma_rdata_q;

  // Arbitration and grants; leaving a burst arbitrates as if the DMA had not waited.
  always_comb begin
    burst_hold = (state == DMA_BURST) && dma_req && dma_lock && (beat_cnt < BURST_MAX);
    wait_eff   = (state == DMA_BURST) ? '0 : wait_cnt;
    dma_wins   = dma_req && (!cpu_req || (wait_eff == WAIT_MAX));
    cpu_grant  = 1'b0;
    dma_grant  = 1'b0;
    if (!reset) begin
      if (burst_hold) begin
        dma_grant = 1'b1;
      end else begin
        dma_grant = dma_wins;
        cpu_grant = cpu_req && !dma_wins;
      end
    end
  end

  // Next state, burst beat count and DMA aging counter.
  always_comb begin
    state_next = IDLE;
    beat_next  = '0;
    wait_next  = wait_cnt;
    open_arb   = cpu_req ? CPU_OWN : (dma_req ? DMA_OWN : IDLE);

    if (burst_hold) begin
      beat_next  = beat_cnt + BEAT_W'(1);
      state_next = (beat_next == BURST_MAX) ? open_arb : DMA_BURST;
    end else if (dma_grant && dma_lock) begin
      beat_next  = BEAT_W'(1);
      state_next = (beat_next == BURST_MAX) ? open_arb : DMA_BURST;
    end else if (cpu_grant) begin
      state_next = CPU_OWN;
    end else if (dma_grant) begin
      state_next = DMA_OWN;
    end

    if (dma_grant) begin
      wait_next = '0;
    end else if (dma_req && (wait_cnt < WAIT_MAX)) begin
      wait_next = wait_cnt + WAIT_W'(1);
    end
  end

  always_comb begin
    mem_addr  = dma_grant ? dma_addr  : cpu_addr;
    mem_din   = dma_grant ? dma_wdata : cpu_wdata;
    mem_read  = (cpu_grant && !cpu_we) || (dma_grant && !dma_we);
    mem_write = (cpu_grant && cpu_we)  || (dma_grant && dma_we);
    cpu_stall = cpu_req && !cpu_grant && !reset;
    dma_gnt   = dma_grant;
  end

  // Read data comes straight from the memory in the return cycle; the held copy covers idle cycles.
  always_comb begin
    cpu_rvalid = tag_cpu && !reset;
    dma_rvalid = tag_dma && !reset;
    cpu_rdata  = cpu_rvalid ? mem_dout : cpu_rdata_q;
    dma_rdata  = dma_rvalid ? mem_dout : dma_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      beat_cnt    <= '0;
      tag_cpu     <= 1'b0;
      tag_dma     <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      beat_cnt <= beat_next;
      tag_cpu  <= cpu_grant && !cpu_we;
      tag_dma  <= dma_grant && !dma_we;
      if (cpu_rvalid) begin
        cpu_rdata_q <= mem_dout;
      end
      if (dma_rvalid) begin
        dma_rdata_q <= mem_dout;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DMEM_ADDR_WIDTH, default 10, is the data memory word-address width.
REQ-002 Parameter REG_WIDTH, default 32, is the data width.
REQ-003 Parameter MAX_WAIT, default 4, is the number of cycles a blocked DMA request waits before it takes priority.
REQ-004 Parameter MAX_BURST, default 8, is the maximum number of beats in one locked DMA burst.
REQ-005 Port clk, input, 1, system clock; one clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1, synchronous active-high reset.
REQ-007 Ports cpu_req / cpu_we, input, 1 each, MEM-stage access request and write flag.
REQ-008 Ports cpu_addr / cpu_wdata, input, DMEM_ADDR_WIDTH / REG_WIDTH, MEM-stage access address and store data.
REQ-009 Ports cpu_stall, output, 1: freeze the pipeline; cpu_rdata, output, REG_WIDTH: load data; cpu_rvalid, output, 1: load data valid.
REQ-010 Ports dma_req / dma_we / dma_lock, input, 1 each: loader request, write flag, and burst-hold request.
REQ-011 Ports dma_addr / dma_wdata, input, DMEM_ADDR_WIDTH / REG_WIDTH, loader access address and write data.
REQ-012 Ports dma_gnt, output, 1: access accepted this cycle; dma_rdata, output, REG_WIDTH: read data; dma_rvalid, output, 1: read data valid.
REQ-013 Ports mem_addr / mem_din, output, DMEM_ADDR_WIDTH / REG_WIDTH, address and write data to the dmem.
REQ-014 Ports mem_read / mem_write, output, 1 each, dmem read and write strobes.
REQ-015 Port mem_dout, input, REG_WIDTH, dmem read data, valid one cycle after mem_read.

Function
REQ-016 The block SHALL grant at most one requester per cycle and drive mem_* combinationally from the granted port; with no grant, mem_read=mem_write=0.
REQ-017 The FSM SHALL have states IDLE, CPU_OWN, DMA_OWN, and DMA_BURST.
REQ-018 In IDLE, CPU_OWN, and DMA_OWN, arbitration SHALL be:
- CPU wins by default.
- DMA wins if the CPU is idle.
- DMA wins if wait_cnt == MAX_WAIT.
REQ-019 The next state SHALL be CPU_OWN or DMA_OWN according to the winner, or IDLE if there is no request.
REQ-020 wait_cnt SHALL increment, saturating at MAX_WAIT, each cycle dma_req=1 and dma_gnt=0, and SHALL clear on dma_gnt.
REQ-021 A DMA grant with dma_lock=1 SHALL enter DMA_BURST with beat_cnt=1.
REQ-022 In DMA_BURST, DMA SHALL own the memory exclusively, and beat_cnt SHALL increment on each granted beat.
REQ-023 DMA_BURST SHALL be exited when dma_lock=0, when dma_req=0, or after the grant making beat_cnt == MAX_BURST; the next state is then decided per REQ-018 with wait_cnt treated as 0.
REQ-024 cpu_stall SHALL equal cpu_req & ~cpu_grant, combinationally in the same cycle.
REQ-025 dma_gnt SHALL be asserted combinationally in the granted cycle.
REQ-026 A granted read SHALL return data exactly 1 cycle later:
- The requester's rvalid is high for one cycle.
- rdata = mem_dout.
- A registered return-tag selects the destination.
REQ-027 rdata SHALL hold its last value while rvalid=0.
REQ-028 Writes SHALL complete in the grant cycle and SHALL NOT raise rvalid.
REQ-029 Back-to-back reads from alternating owners SHALL each return to the correct port; tag and data SHALL never be crossed.
REQ-030 A cpu_req dropped while stalled SHALL be treated as withdrawn, with no pending state kept.

Reset
REQ-031 While reset=1 at a clock edge, the state SHALL become IDLE.
REQ-032 Reset SHALL clear wait_cnt, beat_cnt, and the return-tag to 0.
REQ-033 Reset SHALL clear cpu_rvalid, dma_rvalid, cpu_rdata, and dma_rdata to 0.
REQ-034 During reset, all grants SHALL be forced low, mem_read=mem_write=0, and cpu_stall=0.
REQ-035 Reset asserted mid-burst or with a read in flight SHALL discard the transaction, with no rvalid in the following cycle.

Verification
REQ-036 CPU-only read: cpu_req=1, cpu_we=0, cpu_addr=5, mem holds 0x0000_00AB at address 5 -> mem_read=1 in cycle 0, cpu_stall=0 throughout, cpu_rvalid=1 with cpu_rdata=0x0000_00AB in cycle 1.
REQ-037 Contention with MAX_WAIT=4: cpu_req and dma_req held 1 -> CPU granted for 4 cycles, then dma_gnt=1 with cpu_stall=1 in the 5th cycle, then CPU granted again.
REQ-038 Burst with MAX_BURST=8: dma_lock=1, dma_req=1, and cpu_req=1 all held -> 8 consecutive dma_gnt cycles with cpu_stall=1, then CPU granted on cycle 9.
REQ-039 Burst early exit: dma_lock dropped after 3 beats -> CPU granted on the next cycle, and beat_cnt restarts on the next burst.
REQ-040 Interleaved reads: DMA reads address 2 (0x22) in cycle 0, CPU reads address 3 (0x33) in cycle 1 -> dma_rvalid with 0x22 in cycle 1 and cpu_rvalid with 0x33 in cycle 2, with no cross-delivery.
REQ-041 Reset during a read: reset=1 in the cycle after a granted DMA read -> dma_rvalid=0 and the state is IDLE afterwards.
